// File: rtl/register_bank.sv
// 32-entry register file with one-hot write select, two registered read ports and a sticky select-error flag.
// Optional write-to-read forwarding is enabled by defining REGISTER_BANK_BYPASS_EN.
module register_bank #(
   parameter int unsigned WIDTH    = 32,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [31:0]      wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [4:0]       rd_addr_a,
   input  logic [4:0]       rd_addr_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             sel_err
);

   localparam int unsigned NREGS = 32;

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
   logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
   logic             sel_err_q, sel_err_d;

   logic             wr_valid;
   logic [NREGS-1:0] wr_commit;

   // Write qualification: exactly one known bit set; register 0 masked when hardwired.
   always_comb begin
      wr_valid  = 1'b0;
      wr_commit = '0;
      if (wr_en) begin
         wr_valid = !$isunknown(wr_sel) && $onehot(wr_sel);
      end
      if (wr_valid) begin
         wr_commit = wr_sel;
      end
      if (ZERO_REG) begin
         wr_commit[0] = 1'b0;
      end
   end

   // Next-state for storage, read ports and error flag.
   always_comb begin
      regs_d      = regs_q;
      rd_data_a_d = regs_q[rd_addr_a];
      rd_data_b_d = regs_q[rd_addr_b];
      sel_err_d   = sel_err_q | (wr_en & ~wr_valid);

      for (int k = 0; k < NREGS; k++) begin
         if (wr_commit[k]) begin
            regs_d[k] = wr_data;
         end
      end

`ifdef REGISTER_BANK_BYPASS_EN
      if (wr_commit[rd_addr_a]) begin
         rd_data_a_d = wr_data;
      end
      if (wr_commit[rd_addr_b]) begin
         rd_data_b_d = wr_data;
      end
`else
      // Same-cycle hazards are resolved upstream; reads see pre-edge contents.
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NREGS; k++) begin
            regs_q[k] <= '0;
         end
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         sel_err_q   <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
         sel_err_q   <= sel_err_d;
      end
   end

   assign rd_data_a = rd_data_a_q;
   assign rd_data_b = rd_data_b_q;
   assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank; runs ZERO_REG=1 and ZERO_REG=0 instances side by side.
// Expectations follow REGISTER_BANK_BYPASS_EN when it is defined.
module tb_register_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_sel;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic [31:0] z_rd_a, z_rd_b, n_rd_a, n_rd_b;
   logic        z_err, n_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   register_bank #(.WIDTH(32), .ZERO_REG(1'b1)) dut_z (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(z_rd_a), .rd_data_b(z_rd_b), .sel_err(z_err)
   );

   register_bank #(.WIDTH(32), .ZERO_REG(1'b0)) dut_n (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(n_rd_a), .rd_data_b(n_rd_b), .sel_err(n_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] x_sel;
      logic [31:0] exp_fwd;

      rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
      rd_addr_a = '0; rd_addr_b = '0;
      tick();
      rst = 1'b0;
      check("rst_err_z", 32'(z_err), 32'd0);
      check("rst_err_n", 32'(n_err), 32'd0);

      // Every index reads zero after reset on both ports.
      for (int i = 0; i < 32; i++) begin
         rd_addr_a = 5'(i);
         rd_addr_b = 5'(31 - i);
         tick();
         check("rst_rd_a_z", z_rd_a, 32'h0);
         check("rst_rd_b_z", z_rd_b, 32'h0);
         check("rst_rd_a_n", n_rd_a, 32'h0);
         check("rst_rd_b_n", n_rd_b, 32'h0);
      end
      check("rst_err_z2", 32'(z_err), 32'd0);

      // Write register 5; neighbour 4 stays zero.
      wr_en = 1'b1; wr_sel = 32'h0000_0020; wr_data = 32'hDEAD_BEEF;
      rd_addr_a = 5'd5; rd_addr_b = 5'd4;
      tick();
`ifdef REGISTER_BANK_BYPASS_EN
      exp_fwd = 32'hDEAD_BEEF;
`else
      exp_fwd = 32'h0;
`endif
      check("wr5_same_edge", z_rd_a, exp_fwd);
      wr_en = 1'b0;
      tick();
      check("wr5_rd_a_z", z_rd_a, 32'hDEAD_BEEF);
      check("wr5_rd_a_n", n_rd_a, 32'hDEAD_BEEF);
      check("rd4_b_z", z_rd_b, 32'h0);
      rd_addr_b = 5'd5;
      tick();
      check("same_reg_a", z_rd_a, 32'hDEAD_BEEF);
      check("same_reg_b", z_rd_b, 32'hDEAD_BEEF);

      // Register 0: hardwired in dut_z, ordinary in dut_n.
      wr_en = 1'b1; wr_sel = 32'h0000_0001; wr_data = 32'hFFFF_FFFF;
      rd_addr_a = 5'd0; rd_addr_b = 5'd0;
      tick();
      check("wr0_fwd_z", z_rd_a, 32'h0);
      wr_en = 1'b0;
      tick();
      check("wr0_rd_z", z_rd_a, 32'h0);
      check("wr0_rd_n", n_rd_a, 32'hFFFF_FFFF);
      check("wr0_err_z", 32'(z_err), 32'd0);
      check("wr0_err_n", 32'(n_err), 32'd0);

      // Seed register 1, then present malformed selects.
      wr_en = 1'b1; wr_sel = 32'h0000_0002; wr_data = 32'h1111_1111;
      tick();
      check("seed_err_z", 32'(z_err), 32'd0);

      wr_sel = 32'h0000_0003; wr_data = 32'hBAD0_BAD0;
      tick();
      check("multi_err_z", 32'(z_err), 32'd1);
      check("multi_err_n", 32'(n_err), 32'd1);
      wr_en = 1'b0; rd_addr_a = 5'd0; rd_addr_b = 5'd1;
      tick();
      check("multi_r0_z", z_rd_a, 32'h0);
      check("multi_r1_z", z_rd_b, 32'h1111_1111);
      check("multi_r0_n", n_rd_a, 32'hFFFF_FFFF);
      check("multi_r1_n", n_rd_b, 32'h1111_1111);

      wr_en = 1'b1; wr_sel = 32'h0;
      tick();
      wr_en = 1'b0;
      tick();
      check("zero_r0_n", n_rd_a, 32'hFFFF_FFFF);
      check("zero_r1_n", n_rd_b, 32'h1111_1111);
      check("zero_err_n", 32'(n_err), 32'd1);

      x_sel = {23'b0, 1'bx, 6'b0, 2'b11};
      wr_en = 1'b1; wr_sel = x_sel;
      tick();
      wr_en = 1'b0; wr_sel = '0;
      tick();
      check("x_r0_z", z_rd_a, 32'h0);
      check("x_r1_z", z_rd_b, 32'h1111_1111);
      check("x_r0_n", n_rd_a, 32'hFFFF_FFFF);
      check("x_r1_n", n_rd_b, 32'h1111_1111);
      check("x_err_z", 32'(z_err), 32'd1);

      // wr_en low with an unknown select raises nothing.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_err_z", 32'(z_err), 32'd0);
      wr_en = 1'b0; wr_sel = 'x;
      tick();
      tick();
      check("idle_x_err_z", 32'(z_err), 32'd0);
      check("idle_x_err_n", 32'(n_err), 32'd0);
      wr_sel = '0;

      // Same-edge write and read of register 7.
      wr_en = 1'b1; wr_sel = 32'h0000_0080; wr_data = 32'h0BAD_F00D;
      rd_addr_a = 5'd1; rd_addr_b = 5'd1;
      tick();
      wr_data = 32'h1234_5678; rd_addr_a = 5'd7;
      tick();
`ifdef REGISTER_BANK_BYPASS_EN
      exp_fwd = 32'h1234_5678;
`else
      exp_fwd = 32'h0BAD_F00D;
`endif
      check("r7_same_edge", z_rd_a, exp_fwd);
      wr_en = 1'b0;
      tick();
      check("r7_next", z_rd_a, 32'h1234_5678);
      check("r7_next_n", n_rd_a, 32'h1234_5678);

      // Reset overrides a concurrent write after an error.
      wr_en = 1'b1; wr_sel = 32'h0000_0003;
      tick();
      check("pre_rst_err", 32'(z_err), 32'd1);
      wr_sel = 32'h0000_0008; wr_data = 32'h3333_3333; rst = 1'b1;
      tick();
      rst = 1'b0; wr_en = 1'b0; wr_sel = '0;
      rd_addr_a = 5'd3; rd_addr_b = 5'd7;
      check("rst_wr_err_z", 32'(z_err), 32'd0);
      check("rst_wr_rd_a", z_rd_a, 32'h0);
      tick();
      check("rst_r3_z", z_rd_a, 32'h0);
      check("rst_r3_n", n_rd_a, 32'h0);
      check("rst_r7_z", z_rd_b, 32'h0);
      tick();
      check("rst_r3_z2", z_rd_a, 32'h0);
      check("rst_err_z3", 32'(z_err), 32'd0);
      check("rst_err_n3", 32'(n_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_bank.md
# register_bank

32-entry general-purpose register file for the datapath, sitting directly downstream of the 5-to-32 register-write decoder. It takes the decoder's one-hot write-select vector together with write data and a write strobe, and commits the data into the selected register on the clock edge. It provides two registered read ports for the operand-fetch stage. Malformed select vectors (zero-hot, multi-hot, or unknown) are rejected and flagged.

## Interface
Parameters:
- `WIDTH`, 32, data width of every register and read/write port.
- `ZERO_REG`, 1; when 1, register 0 is hardwired to zero and writes to it are discarded; when 0, register 0 is an ordinary register.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset; sampled on the rising edge of `clk`.
- `wr_en` input 1: write strobe; qualifies `wr_sel`/`wr_data`.
- `wr_sel` input 32: one-hot write select from the decoder; bit k selects register k.
- `wr_data` input WIDTH: data to write.
- `rd_addr_a` input 5: read port A register index.
- `rd_addr_b` input 5: read port B register index.
- `rd_data_a` output WIDTH: registered read data, port A.
- `rd_data_b` output WIDTH: registered read data, port B.
- `sel_err` output 1: sticky flag; set when a write was rejected because `wr_sel` was not one-hot.

## Operation
- Storage: 32 × WIDTH flops, `regs[0..31]`.
- Write is valid when `wr_en`=1 and `wr_sel` has exactly one bit set, with no X/Z bits. The index is k = position of the set bit.
  - Valid write, and not (`ZERO_REG`=1 and k=0): `regs[k] <= wr_data`.
  - Valid write with k=0 and `ZERO_REG`=1: silently discarded. No error is raised.
  - `wr_en`=1 with `wr_sel` zero-hot, multi-hot, or containing X/Z: no register changes, and `sel_err <= 1`.
  - `wr_en`=0: `wr_sel` is ignored entirely, including X values. No error is raised.
- Read: on each edge, `rd_data_a <= regs[rd_addr_a]` and `rd_data_b <= regs[rd_addr_b]`, using pre-edge contents unless bypass is enabled (see Configuration).
- With `ZERO_REG`=1, a read of index 0 always returns 0.
- Both ports may read the same register in the same cycle and return identical data.
- `sel_err` clears only on `rst`.
- Reset, in the cycle `rst`=1 at the edge:
  - all `regs` <= 0
  - `rd_data_a` <= 0 and `rd_data_b` <= 0
  - `sel_err` <= 0
  - Reset overrides any concurrent write or error in the same cycle.
- Reset mid-operation: any write presented in the reset cycle is lost. Normal operation resumes on the first edge with `rst`=0.

## Timing
- Write latency: data presented at edge N is stored at edge N and is visible to reads sampled at edge N+1, so it appears on `rd_data_*` after edge N+1.
- Read latency: 1 cycle, from address sampled at edge N to data valid after edge N.
- `sel_err` rises after the same edge that rejects the write.
- No handshake and no stalls: one write and two reads are accepted every cycle.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- Macro: `REGISTER_BANK_BYPASS_EN`.
- Defined: write-to-read forwarding. If a valid, committed write to register k occurs at edge N and `rd_addr_x` = k at the same edge, then `rd_data_x <= wr_data`, so a same-cycle read sees the new value.
  - Discarded writes to register 0 with `ZERO_REG`=1 are not forwarded.
  - Rejected writes are not forwarded.
- Not defined: reads at edge N return the pre-edge contents. Forwarding is then the hazard unit's responsibility.

## Test plan
- Reset, then read all 32 indices on both ports -> every `rd_data_*` = 0 and `sel_err` = 0.
- Write `wr_sel`=32'h0000_0020 (bit 5) with `wr_data`=32'hDEAD_BEEF, then read `rd_addr_a`=5 next cycle -> `rd_data_a`=32'hDEAD_BEEF.
  - Read of `rd_addr_b`=4 in the same cycle -> `rd_data_b` = 0.
- Write to register 0 with `wr_sel`=32'h1 and `wr_data`=32'hFFFF_FFFF (`ZERO_REG`=1), then read 0 -> 0 and `sel_err` = 0.
  - Repeat with `ZERO_REG`=0 -> reads 32'hFFFF_FFFF.
- `wr_en`=1 with `wr_sel`=32'h0000_0003, then separately `wr_sel`=0, then separately `wr_sel` containing X:
  - registers 0 and 1 are unchanged in every case;
  - `sel_err`=1 after the first rejecting edge and stays 1;
  - `wr_en`=0 with `wr_sel`=X raises no error.
- Same-edge write to register 7 (32'h1234_5678) with `rd_addr_a`=7:
  - with `REGISTER_BANK_BYPASS_EN`: `rd_data_a`=32'h1234_5678 after that edge;
  - without it: the old value, with 32'h1234_5678 appearing one cycle later.
- Assert `rst` while `wr_en`=1 to register 3 after `sel_err` was set -> register 3 reads 0 and `sel_err`=0 on the following cycles.
